riscv_if_parcel_queue: RTL

RISCV_IF_PARCEL_QUEUE -- requirements
Module: riscv_if_parcel_queue

---
 rtl/riscv_if_parcel_queue_pkg.sv | 27 ++
 rtl/riscv_if_parcel_queue_if.sv | 51 +++++
 rtl/riscv_ifq_mem.sv | 36 +++
 rtl/riscv_if_parcel_queue.sv | 98 +++++++++
 4 files changed

// File: rtl/riscv_if_parcel_queue_pkg.sv
// Shared definitions for the fetch-to-decode parcel queue.
//
// Contents:
//   IFQ_XLEN / IFQ_PARCEL_SIZE / IFQ_DEPTH : default PC width, parcel width, queue depth
//   ifq_entry_t                            : one queue entry {pc, parcel, misaligned}
//   ifq_entry_width()                      : packed entry width for arbitrary widths
//
// The storage array keeps entries as flat vectors laid out exactly like
// ifq_entry_t (pc in the MSBs, misaligned flag in the LSB), so that
// non-default XLEN/PARCEL_SIZE builds still work.
package riscv_if_parcel_queue_pkg;

  localparam int IFQ_XLEN        = 64;
  localparam int IFQ_PARCEL_SIZE = 32;
  localparam int IFQ_DEPTH       = 4;

  typedef struct packed {
    logic [IFQ_XLEN-1:0]        pc;
    logic [IFQ_PARCEL_SIZE-1:0] parcel;
    logic                       misaligned;
  } ifq_entry_t;

  function automatic int ifq_entry_width(input int xlen, input int parcel_size);
    return xlen + parcel_size + 1;
  endfunction

endpackage

// File: rtl/riscv_if_parcel_queue_if.sv
// Fetch/decode bundle of the parcel queue.
//
// Signals:
//   if_parcel_pc, if_parcel, if_parcel_valid, if_parcel_misaligned : parcel from fetch
//   if_stall                                                       : back-pressure to fetch
//   id_flush, id_stall                                             : flush / decode-not-ready
//   id_pc, id_instr, id_misaligned, id_valid                       : head entry to decode
//   ifq_count                                                      : occupancy
//
// Handshake: a parcel is taken from fetch on a rising edge where
// if_parcel_valid=1, id_flush=0 and the queue is not full; fetch must hold
// the parcel (unchanged) while if_stall=1. Decode takes the head entry on a
// rising edge where id_valid=1 and id_stall=0.
//
// Modports: slave = the queue, master = the environment (fetch + decode).
interface riscv_if_parcel_queue_if
  import riscv_if_parcel_queue_pkg::*;
#(
  parameter int XLEN        = IFQ_XLEN,
  parameter int PARCEL_SIZE = IFQ_PARCEL_SIZE,
  parameter int DEPTH       = IFQ_DEPTH
) ();

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0]        if_parcel_pc;
  logic [PARCEL_SIZE-1:0] if_parcel;
  logic                   if_parcel_valid;
  logic                   if_parcel_misaligned;
  logic                   if_stall;
  logic                   id_flush;
  logic                   id_stall;
  logic [XLEN-1:0]        id_pc;
  logic [PARCEL_SIZE-1:0] id_instr;
  logic                   id_misaligned;
  logic                   id_valid;
  logic [CW-1:0]          ifq_count;

  modport slave (
    input  if_parcel_pc, if_parcel, if_parcel_valid, if_parcel_misaligned,
    input  id_flush, id_stall,
    output if_stall, id_pc, id_instr, id_misaligned, id_valid, ifq_count
  );

  modport master (
    output if_parcel_pc, if_parcel, if_parcel_valid, if_parcel_misaligned,
    output id_flush, id_stall,
    input  if_stall, id_pc, id_instr, id_misaligned, id_valid, ifq_count
  );

endinterface

// File: rtl/riscv_ifq_mem.sv
// Entry storage for the parcel queue: DEPTH x WIDTH register array with one
// synchronous write port and one asynchronous read port. Not reset; the
// queue pointers alone decide which entries are meaningful.
//
// Ports:
//   clk   : clock
//   we    : write enable
//   waddr : write index
//   wdata : write entry
//   raddr : read index
//   rdata : entry at raddr (combinational)
module riscv_ifq_mem
  import riscv_if_parcel_queue_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH,
  parameter int WIDTH = ifq_entry_width(IFQ_XLEN, IFQ_PARCEL_SIZE)
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/riscv_if_parcel_queue.sv
// Instruction-parcel FIFO between the fetch core and decode.
//
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset (clears pointers, not storage)
//   bus : riscv_if_parcel_queue_if.slave (fetch side, decode side, occupancy)
//
// Build option: RISCV_IFQ_BYPASS_EN -- when defined, a parcel arriving at an
// empty queue is forwarded combinationally to decode in the same cycle; it
// is stored only if decode does not take it that cycle. When undefined there
// is no combinational path from fetch inputs to decode outputs and a pushed
// parcel becomes visible one cycle later.
//
// DEPTH must be a power of two, >= 2. Pointers carry one extra wrap bit so
// full and empty are distinguishable without a separate counter.
module riscv_if_parcel_queue
  import riscv_if_parcel_queue_pkg::*;
#(
  parameter int XLEN        = IFQ_XLEN,
  parameter int PARCEL_SIZE = IFQ_PARCEL_SIZE,
  parameter int DEPTH       = IFQ_DEPTH
) (
  input logic                    clk,
  input logic                    rst,
  riscv_if_parcel_queue_if.slave bus
);

  localparam int AW      = $clog2(DEPTH);
  localparam int PW      = AW + 1;
  localparam int ENTRY_W = ifq_entry_width(XLEN, PARCEL_SIZE);

  logic [PW-1:0]      wptr;
  logic [PW-1:0]      rptr;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] wdata;
  logic [ENTRY_W-1:0] rdata;

  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty = (wptr == rptr);

  // Difference modulo 2*DEPTH gives 0..DEPTH directly.
  assign bus.ifq_count = wptr - rptr;

  // Depends only on registered pointers and id_flush.
  assign bus.if_stall = full | bus.id_flush;

  assign wdata = {bus.if_parcel_pc, bus.if_parcel, bus.if_parcel_misaligned};

`ifdef RISCV_IFQ_BYPASS_EN
  logic bypass;

  // Incoming parcel is presented directly when nothing is queued ahead of it.
  assign bypass       = empty & bus.if_parcel_valid & ~bus.id_flush;
  assign bus.id_valid = (~empty | bus.if_parcel_valid) & ~bus.id_flush;
  assign {bus.id_pc, bus.id_instr, bus.id_misaligned} = empty ? wdata : rdata;

  // Only stored entries advance the read pointer; a bypassed parcel that
  // decode accepts is never written.
  assign pop  = ~empty & ~bus.id_flush & ~bus.id_stall;
  assign push = bus.if_parcel_valid & ~bus.id_flush & ~full & ~(bypass & ~bus.id_stall);
`else
  assign bus.id_valid = ~empty & ~bus.id_flush;
  assign {bus.id_pc, bus.id_instr, bus.id_misaligned} = rdata;

  assign pop  = bus.id_valid & ~bus.id_stall;
  assign push = bus.if_parcel_valid & ~bus.id_flush & ~full;
`endif

  always_ff @(posedge clk) begin
    if (rst || bus.id_flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + PW'(1);
      end
      if (pop) begin
        rptr <= rptr + PW'(1);
      end
    end
  end

  riscv_ifq_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wptr[AW-1:0]),
    .wdata (wdata),
    .raddr (rptr[AW-1:0]),
    .rdata (rdata)
  );

endmodule
